// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor (ovf when SERSUB_OVF_EN)
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
`ifdef SERSUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
`ifdef SERSUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first a-b with single borrow flop; SERSUB_OVF_EN adds signed overflow
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             bout_q;
  logic             d;
  logic             brw_next;
  logic             last_bit;
  logic             accept;
`ifdef SERSUB_OVF_EN
  logic             ovf_q;
`endif

  assign d        = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
  // A new request is only taken when no subtraction is in flight
  assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: run WIDTH bit cycles, pulse DONE once, allow back-to-back start from DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, then shift one difference bit into the MSB per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      diff_q <= {d, diff_q[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      brw    <= brw_next;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        bout_q <= brw_next;
`ifdef SERSUB_OVF_EN
        // On the last bit the shift registers expose the operand sign bits and d is the result sign
        ovf_q  <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) intf ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: plain modular and signed arithmetic on the operand values
  function automatic int ref_diff(input int a, input int b);
    return (a - b) & MASK;
  endfunction

  function automatic int ref_bout(input int a, input int b);
    return (a < b) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(input int a, input int b);
    int sa, sb, r;
    sa = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
    sb = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
    r  = sa - sb;
    return (r > (1 << (WIDTH - 1)) - 1 || r < -(1 << (WIDTH - 1))) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands at a sample point; the next edge accepts them, then scramble inputs
  task automatic start_op(input int a, input int b);
    intf.start = 1'b1;
    intf.a = WIDTH'(a);
    intf.b = WIDTH'(b);
    tick();
    intf.start = 1'b0;
    intf.a = WIDTH'($urandom);
    intf.b = WIDTH'($urandom);
  endtask

  // Walk the busy window and check the result on the done cycle; optionally poke start mid-run
  task automatic finish_op(input string tag, input int a, input int b, input bit interfere);
    for (int i = 0; i < WIDTH; i++) begin
      check({tag, " busy"}, int'(intf.busy), 1);
      check({tag, " done_early"}, int'(intf.done), 0);
      if (interfere && i == 1) begin
        intf.start = 1'b1;
        intf.a = 4'd1;
        intf.b = 4'd1;
      end
      tick();
      if (interfere && i == 1) intf.start = 1'b0;
    end
    check({tag, " done"}, int'(intf.done), 1);
    check({tag, " busy_off"}, int'(intf.busy), 0);
    check({tag, " diff"}, int'(intf.diff), ref_diff(a, b));
    check({tag, " bout"}, int'(intf.bout), ref_bout(a, b));
`ifdef SERSUB_OVF_EN
    check({tag, " ovf"}, int'(intf.ovf), ref_ovf(a, b));
`endif
  endtask

  task automatic full_op(input string tag, input int a, input int b);
    start_op(a, b);
    finish_op(tag, a, b, 1'b0);
    tick();
    check({tag, " pulse"}, int'(intf.done), 0);
    check({tag, " held"}, int'(intf.diff), ref_diff(a, b));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"}, int'(intf.busy), 0);
    check({tag, " done"}, int'(intf.done), 0);
    check({tag, " diff"}, int'(intf.diff), 0);
    check({tag, " bout"}, int'(intf.bout), 0);
`ifdef SERSUB_OVF_EN
    check({tag, " ovf"}, int'(intf.ovf), 0);
`endif
  endtask

  initial begin
    int ra, rb, pa, pb;
    intf.start = 1'b0;
    intf.a = '0;
    intf.b = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    full_op("9-3", 9, 3);
    full_op("3-9", 3, 9);
    full_op("0-1", 0, 1);
    full_op("0-0", 0, 0);
    full_op("8-1", 8, 1);
    full_op("7-1", 7, 1);
    full_op("F-F", 15, 15);
    full_op("7-8", 7, 8);

    // Start during RUN must be ignored
    start_op(5, 2);
    finish_op("ignore", 5, 2, 1'b1);
    tick();
    check("ignore pulse", int'(intf.done), 0);
    check("ignore idle", int'(intf.busy), 0);

    // Reset mid-run aborts with no done pulse
    start_op(6, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("abort");
    for (int i = 0; i < WIDTH + 2; i++) begin
      check("abort no_done", int'(intf.done), 0);
      tick();
    end

    // Reset and start on the same edge: reset wins
    rst = 1'b1;
    intf.start = 1'b1;
    intf.a = 4'd9;
    intf.b = 4'd2;
    tick();
    rst = 1'b0;
    intf.start = 1'b0;
    check_reset_state("rst_start");
    tick();
    check("rst_start idle", int'(intf.busy), 0);

    // Back-to-back chain: each new start lands on the previous done cycle
    pa = 12; pb = 5;
    start_op(pa, pb);
    for (int k = 0; k < 4; k++) begin
      finish_op("chain", pa, pb, 1'b0);
      pa = int'($urandom_range(0, MASK));
      pb = int'($urandom_range(0, MASK));
      start_op(pa, pb);
    end
    finish_op("chain", pa, pb, 1'b0);
    tick();
    check("chain pulse", int'(intf.done), 0);

    // Randomized operands with idle gaps
    for (int k = 0; k < 24; k++) begin
      ra = int'($urandom_range(0, MASK));
      rb = int'($urandom_range(0, MASK));
      full_op("rand", ra, rb);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        check("rand idle_done", int'(intf.done), 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
